// File: rtl/pc_stage_predictor.sv
// Fetch PC register with a direct-mapped BTB (2-bit direction counters), branch
// resolution against the decode-stage PC, pipeline clears and a mispredict counter.
module pc_stage_predictor #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     BTB_ENTRIES  = 16,
  parameter int unsigned     CNT_WIDTH    = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 STALL,
  input  logic                 EX_VALID,
  input  logic                 EX_IS_JUMP,
  input  logic                 EX_IS_BRANCH,
  input  logic                 EX_TAKEN,
  input  logic [XLEN-1:0]      EX_PC,
  input  logic [XLEN-1:0]      EX_TARGET,
  input  logic [XLEN-1:0]      EX_NEXT_PC,
  output logic [XLEN-1:0]      PC,
  output logic                 PRED_TAKEN,
  output logic                 CLEAR_DECODING_STAGE,
  output logic                 CLEAR_EXECUTION_STAGE,
  output logic [CNT_WIDTH-1:0] MISPREDICT_COUNT
);

  localparam int unsigned IDX  = $clog2(BTB_ENTRIES);
  localparam int unsigned TAGW = XLEN - IDX - 2;

  logic            btb_valid  [BTB_ENTRIES];
  logic [TAGW-1:0] btb_tag    [BTB_ENTRIES];
  logic [XLEN-1:0] btb_target [BTB_ENTRIES];
  logic [1:0]      btb_ctr    [BTB_ENTRIES];

  logic [XLEN-1:0]      pc_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic [IDX-1:0]  pc_idx, ex_idx;
  logic [TAGW-1:0] pc_tag, ex_tag;
  logic            lk_hit, ex_hit;
  logic            pred_taken;
  logic [XLEN-1:0] pred_next;
  logic            resolve, taken, mispredict;
  logic [XLEN-1:0] actual_raw, actual;
  logic [XLEN-1:0] pc_next;

  assign pc_idx = pc_q[IDX+1:2];
  assign pc_tag = pc_q[XLEN-1:IDX+2];
  assign ex_idx = EX_PC[IDX+1:2];
  assign ex_tag = EX_PC[XLEN-1:IDX+2];

  // Lookup reads the pre-update BTB contents; there is no write-through bypass.
  always_comb begin
    lk_hit     = btb_valid[pc_idx] && (btb_tag[pc_idx] == pc_tag);
    pred_taken = lk_hit && btb_ctr[pc_idx][1] && !RST;
    pred_next  = pred_taken ? btb_target[pc_idx] : pc_q + XLEN'(4);
  end

  always_comb begin
    resolve    = EX_VALID && (EX_IS_JUMP || EX_IS_BRANCH) && !STALL && !RST;
    taken      = EX_IS_JUMP || EX_TAKEN;
    actual_raw = taken ? EX_TARGET : EX_PC + XLEN'(4);
    actual     = {actual_raw[XLEN-1:2], 2'b00};
    mispredict = resolve && (actual != EX_NEXT_PC);
    ex_hit     = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);
  end

  always_comb begin
    pc_next = pc_q;
    if (RST)             pc_next = RESET_VECTOR;
    else if (mispredict) pc_next = actual;
    else if (STALL)      pc_next = pc_q;
    else                 pc_next = {pred_next[XLEN-1:2], 2'b00};
  end

  always_ff @(posedge CLK) begin
    pc_q <= pc_next;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (mispredict && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  // Tag and target need no reset: they are only consulted behind a valid bit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i] <= 1'b0;
        btb_ctr[i]   <= 2'b00;
      end
    end else if (resolve) begin
      if (taken) begin
        btb_valid[ex_idx]  <= 1'b1;
        btb_tag[ex_idx]    <= ex_tag;
        btb_target[ex_idx] <= EX_TARGET;
        if (!ex_hit)                        btb_ctr[ex_idx] <= 2'b10;
        else if (btb_ctr[ex_idx] != 2'b11)  btb_ctr[ex_idx] <= btb_ctr[ex_idx] + 2'd1;
      end else if (ex_hit && (btb_ctr[ex_idx] != 2'b00)) begin
        btb_ctr[ex_idx] <= btb_ctr[ex_idx] - 2'd1;
      end
    end
  end

  assign PC                    = pc_q;
  assign PRED_TAKEN            = pred_taken;
  assign CLEAR_DECODING_STAGE  = mispredict;
  assign CLEAR_EXECUTION_STAGE = mispredict;
  assign MISPREDICT_COUNT      = cnt_q;

endmodule

// File: tb/tb_pc_stage_predictor.sv
// Bench for pc_stage_predictor: directed vector table, then randomized traffic
// checked against an address-keyed BTB model.
module tb_pc_stage_predictor;

  localparam int CW = 4;
  localparam int NE = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          STALL = 1'b0, EX_VALID = 1'b0, EX_IS_JUMP = 1'b0, EX_IS_BRANCH = 1'b0, EX_TAKEN = 1'b0;
  logic [31:0]   EX_PC = '0, EX_TARGET = '0, EX_NEXT_PC = '0;
  logic [31:0]   PC;
  logic          PRED_TAKEN, CLEAR_DECODING_STAGE, CLEAR_EXECUTION_STAGE;
  logic [CW-1:0] MISPREDICT_COUNT;

  pc_stage_predictor #(
    .XLEN(32), .RESET_VECTOR(32'h0000_0000), .BTB_ENTRIES(NE), .CNT_WIDTH(CW)
  ) dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .EX_VALID(EX_VALID), .EX_IS_JUMP(EX_IS_JUMP),
    .EX_IS_BRANCH(EX_IS_BRANCH), .EX_TAKEN(EX_TAKEN), .EX_PC(EX_PC), .EX_TARGET(EX_TARGET),
    .EX_NEXT_PC(EX_NEXT_PC), .PC(PC), .PRED_TAKEN(PRED_TAKEN),
    .CLEAR_DECODING_STAGE(CLEAR_DECODING_STAGE), .CLEAR_EXECUTION_STAGE(CLEAR_EXECUTION_STAGE),
    .MISPREDICT_COUNT(MISPREDICT_COUNT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    bit rst, stall, v, j, b, t;
    logic [31:0] epc, etgt, enext;
    bit exp_pred, exp_clr;
    logic [31:0] exp_pc;
    int exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit rst, bit stall, bit v, bit j, bit b, bit t,
                              logic [31:0] epc, logic [31:0] etgt, logic [31:0] enext,
                              bit ep, bit ec, logic [31:0] epcn, int ecnt);
    vec_t x;
    x.rst = rst; x.stall = stall; x.v = v; x.j = j; x.b = b; x.t = t;
    x.epc = epc; x.etgt = etgt; x.enext = enext;
    x.exp_pred = ep; x.exp_clr = ec; x.exp_pc = epcn; x.exp_cnt = ecnt;
    vecs.push_back(x);
  endfunction

  function automatic void idle(bit ep, logic [31:0] epcn, int ecnt);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, ep, 0, epcn, ecnt);
  endfunction

  // Reference model: each BTB slot remembers the full aligned address that owns it.
  bit          m_val [NE];
  logic [31:0] m_own [NE];
  logic [31:0] m_tgt [NE];
  int          m_ctr [NE];
  logic [31:0] m_pc;
  int          m_cnt;
  bit          m_pred, m_misp, m_resolve, m_taken;
  logic [31:0] m_actual, m_next;

  function automatic int slot_of(logic [31:0] a);
    return int'((a >> 2) % NE);
  endfunction

  function automatic bit owns(logic [31:0] a);
    int s = slot_of(a);
    return m_val[s] && (m_own[s] == (a & 32'hFFFF_FFFC));
  endfunction

  task automatic m_reset();
    m_pc = 32'h0; m_cnt = 0;
    for (int i = 0; i < NE; i++) begin m_val[i] = 0; m_ctr[i] = 0; end
  endtask

  task automatic model_comb();
    int s = slot_of(m_pc);
    m_pred    = !RST && owns(m_pc) && (m_ctr[s] >= 2);
    m_resolve = EX_VALID && (EX_IS_JUMP || EX_IS_BRANCH) && !STALL && !RST;
    m_taken   = EX_IS_JUMP || EX_TAKEN;
    m_actual  = (m_taken ? EX_TARGET : EX_PC + 32'd4) & 32'hFFFF_FFFC;
    m_misp    = m_resolve && (m_actual != EX_NEXT_PC);
    if (RST)         m_next = 32'h0;
    else if (m_misp) m_next = m_actual;
    else if (STALL)  m_next = m_pc;
    else             m_next = (m_pred ? m_tgt[s] : m_pc + 32'd4) & 32'hFFFF_FFFC;
  endtask

  task automatic model_edge();
    int s;
    if (RST) begin
      m_reset();
      return;
    end
    if (m_resolve) begin
      s = slot_of(EX_PC);
      if (m_taken) begin
        m_ctr[s] = owns(EX_PC) ? ((m_ctr[s] < 3) ? m_ctr[s] + 1 : 3) : 2;
        m_val[s] = 1;
        m_own[s] = EX_PC & 32'hFFFF_FFFC;
        m_tgt[s] = EX_TARGET;
      end else if (owns(EX_PC) && m_ctr[s] > 0) begin
        m_ctr[s] = m_ctr[s] - 1;
      end
    end
    if (m_misp && m_cnt < (1 << CW) - 1) m_cnt++;
    m_pc = m_next;
  endtask

  function automatic logic [31:0] pick_addr();
    return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, NE - 1)) << 2);
  endfunction

  initial begin
    // Directed sequence; expectations derived by hand from the behaviour rules.
    add(1,0,0,0,0,0, 0,0,0,                 0,0,32'h0,0);
    add(1,0,0,0,0,0, 0,0,0,                 0,0,32'h0,0);
    idle(0, 32'h4, 0); idle(0, 32'h8, 0); idle(0, 32'hC, 0); idle(0, 32'h10, 0);
    add(0,0,1,0,1,1, 32'h10,32'h40,32'h14,  0,1,32'h40,1);
    add(0,0,1,1,0,0, 32'h100,32'h10,32'h104,0,1,32'h10,2);
    idle(1, 32'h40, 2);
    add(0,0,1,0,1,1, 32'h10,32'h40,32'h40,  0,0,32'h44,2);
    add(0,0,1,0,1,0, 32'h10,32'h40,32'h40,  0,1,32'h14,3);
    add(0,0,1,0,1,0, 32'h10,32'h40,32'h40,  0,1,32'h14,4);
    add(0,0,1,1,0,0, 32'h100,32'h10,32'h104,0,1,32'h10,5);
    idle(0, 32'h14, 5);
    for (int k = 0; k < 3; k++)
      add(0,1,1,0,1,1, 32'h200,32'h300,32'h204, 0,0,32'h14,5);
    add(0,0,1,0,1,1, 32'h200,32'h300,32'h204, 0,1,32'h300,6);
    add(0,0,1,0,1,1, 32'h10,32'h40,32'h40,  0,0,32'h304,6);
    add(0,0,1,1,0,0, 32'h300,32'h50,32'h304,0,1,32'h50,7);
    idle(0, 32'h54, 7);
    add(0,0,1,1,0,0, 32'h400,32'hFFFF_FFFC,32'h404, 0,1,32'hFFFF_FFFC,8);
    idle(0, 32'h0, 8);
    add(0,0,1,0,1,1, 32'h700,32'h83,32'h704, 0,1,32'h80,9);
    add(1,0,1,0,1,1, 32'h10,32'h40,32'h14,  0,0,32'h0,0);
    idle(0, 32'h4, 0); idle(0, 32'h8, 0); idle(0, 32'hC, 0); idle(0, 32'h10, 0);
    idle(0, 32'h14, 0);

    foreach (vecs[i]) begin
      @(negedge CLK);
      RST = vecs[i].rst; STALL = vecs[i].stall; EX_VALID = vecs[i].v;
      EX_IS_JUMP = vecs[i].j; EX_IS_BRANCH = vecs[i].b; EX_TAKEN = vecs[i].t;
      EX_PC = vecs[i].epc; EX_TARGET = vecs[i].etgt; EX_NEXT_PC = vecs[i].enext;
      #1;
      check($sformatf("vec%0d pred", i), 32'(PRED_TAKEN), 32'(vecs[i].exp_pred));
      check($sformatf("vec%0d clr_dec", i), 32'(CLEAR_DECODING_STAGE), 32'(vecs[i].exp_clr));
      check($sformatf("vec%0d clr_ex", i), 32'(CLEAR_EXECUTION_STAGE), 32'(vecs[i].exp_clr));
      @(posedge CLK); #1;
      check($sformatf("vec%0d pc", i), PC, vecs[i].exp_pc);
      check($sformatf("vec%0d cnt", i), 32'(MISPREDICT_COUNT), 32'(vecs[i].exp_cnt));
    end

    // Randomized traffic against the model, starting from a clean reset.
    @(negedge CLK);
    RST = 1; STALL = 0; EX_VALID = 0;
    @(posedge CLK); #1;
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] tgt, act;
      @(negedge CLK);
      RST          = ($urandom_range(0, 99) == 0);
      STALL        = ($urandom_range(0, 4) == 0);
      EX_VALID     = ($urandom_range(0, 4) != 0);
      EX_IS_JUMP   = ($urandom_range(0, 3) == 0);
      EX_IS_BRANCH = !EX_IS_JUMP && ($urandom_range(0, 3) != 0);
      EX_TAKEN     = $urandom_range(0, 1) == 1;
      EX_PC        = pick_addr();
      tgt          = pick_addr() | 32'($urandom_range(0, 3));
      EX_TARGET    = tgt;
      act          = ((EX_IS_JUMP || EX_TAKEN) ? tgt : EX_PC + 32'd4) & 32'hFFFF_FFFC;
      EX_NEXT_PC   = ($urandom_range(0, 1) == 1) ? act : pick_addr();
      #1;
      model_comb();
      check("rnd pred", 32'(PRED_TAKEN), 32'(m_pred));
      check("rnd clr_dec", 32'(CLEAR_DECODING_STAGE), 32'(m_misp));
      check("rnd clr_ex", 32'(CLEAR_EXECUTION_STAGE), 32'(m_misp));
      @(posedge CLK); #1;
      model_edge();
      check("rnd pc", PC, m_pc);
      check("rnd cnt", 32'(MISPREDICT_COUNT), 32'(m_cnt));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_stage_predictor.md
Name: pc_stage_predictor

Overview:
- Parametrised program-counter stage with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters.
- Supplies the fetch PC every cycle and predicts the next PC from the BTB.
- Resolves jumps and branches reported by the execution stage and redirects on mispredict, with same-cycle clears of the decode and execute stages.
- Sits between the execution stage and instruction fetch, and keeps a saturating mispredict counter.

Parameters:
XLEN, 32, PC and target width in bits.
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (XLEN bits).
BTB_ENTRIES, 16, number of BTB entries; power of 2, minimum 2.
CNT_WIDTH, 16, width of the mispredict statistics counter.

Ports:
CLK  input  1  clock, rising edge.
RST  input  1  synchronous active-high reset.
STALL  input  1  holds the PC; suppresses resolution and BTB update.
EX_VALID  input  1  execution stage holds a valid instruction.
EX_IS_JUMP  input  1  instruction is JAL/JALR (always taken).
EX_IS_BRANCH  input  1  instruction is a conditional branch.
EX_TAKEN  input  1  branch outcome (ignored when EX_IS_JUMP=1).
EX_PC  input  XLEN  PC of the execution-stage instruction.
EX_TARGET  input  XLEN  computed jump/branch target.
EX_NEXT_PC  input  XLEN  PC of the instruction fetched after EX_PC (decode-stage PC).
PC  output  XLEN  current fetch PC.
PRED_TAKEN  output  1  BTB predicts taken for the current PC.
CLEAR_DECODING_STAGE  output  1  flush decode.
CLEAR_EXECUTION_STAGE  output  1  flush execute.
MISPREDICT_COUNT  output  CNT_WIDTH  saturating mispredict count.

Behaviour:
- IDX = log2(BTB_ENTRIES).
- Index = PC[IDX+1:2]; tag = PC[XLEN-1:IDX+2].
- Each entry holds a valid bit, a tag, an XLEN target and a 2-bit counter.
- Reset (synchronous, applied on the clock edge with RST=1):
  - PC <= RESET_VECTOR.
  - All BTB valid bits and counters <= 0.
  - MISPREDICT_COUNT <= 0.
  - RST overrides all other inputs in that cycle.
- Lookup (combinational on PC):
  - hit = valid & tag match.
  - PRED_TAKEN = hit & ctr[1].
  - pred_next = PRED_TAKEN ? btb_target : PC+4.
  - PRED_TAKEN is 0 while RST=1.
- Resolution (combinational) applies only when resolve = EX_VALID & (EX_IS_JUMP|EX_IS_BRANCH) & !STALL & !RST:
  - taken = EX_IS_JUMP | EX_TAKEN.
  - actual = taken ? EX_TARGET : EX_PC+4, with bits[1:0] forced to 0.
  - mispredict = resolve & (actual != EX_NEXT_PC).
- CLEAR_DECODING_STAGE = CLEAR_EXECUTION_STAGE = mispredict. This is same-cycle and combinational, and both are 0 in all other cycles including reset.
- Next-PC priority, registered on the rising edge:
  1. RST: RESET_VECTOR.
  2. mispredict: actual.
  3. STALL: hold PC.
  4. otherwise: pred_next with bits[1:0] forced to 0.
- Latency: a redirect is visible on PC one cycle after the mispredict cycle.
- BTB update on the edge when resolve=1, at the index/tag of EX_PC:
  - Hit, taken: ctr saturating +1 (max 3); target <= EX_TARGET.
  - Hit, not taken: ctr saturating -1 (min 0); target unchanged.
  - Miss, taken: allocate/replace; valid=1, tag written, target=EX_TARGET, ctr=2'b10.
  - Miss, not taken: no change.
  - Jumps always update as taken, so a JALR target is refreshed each resolution.
- Simultaneous lookup and update on the same index: lookup uses the pre-update contents; there is no bypass.
- MISPREDICT_COUNT increments by 1 on each edge with mispredict=1 and saturates at 2^CNT_WIDTH-1.
- Arithmetic: PC+4 and EX_PC+4 are XLEN-bit unsigned and wrap modulo 2^XLEN (32'hFFFF_FFFC+4 = 0).
- STALL=1 with EX_VALID=1: no clear, no BTB change, no counter change, PC holds. Resolution occurs on the first unstalled cycle.
- RST asserted mid-redirect: reset wins, and the BTB update in that cycle is discarded.

Test Plan:
- Reset with RST=1 for 2 cycles, then released, STALL=0 and EX_VALID=0 -> PC = 0, 4, 8, 12 on successive cycles; PRED_TAKEN=0; clears=0.
- Branch at EX_PC=0x10 taken to 0x40 while EX_NEXT_PC=0x14 -> CLEAR_* =1 that cycle; next PC=0x40; MISPREDICT_COUNT=1; BTB entry 4 valid with ctr=2.
- PC reaches 0x10 again after the allocate -> PRED_TAKEN=1 and next PC=0x40. Resolve taken with EX_NEXT_PC=0x40 -> no clear; ctr=3.
- Same branch resolved not-taken twice with EX_NEXT_PC=0x40 -> each mispredicts to 0x14 and ctr goes 3->2->1. PC=0x10 then predicts not taken, giving next PC 0x14.
- STALL=1 for 3 cycles during a mispredicting branch -> PC held, clears=0, BTB unchanged. On release: clear pulse for 1 cycle and redirect.
- Aliasing with BTB_ENTRIES=16: entry allocated for 0x10, then 0x50 (same index, different tag) -> no false hit. JAL at 0xFFFF_FFFC with no BTB entry advances PC to 0 (wrap) before resolution.
